pixel_compositor_pipe: RTL

- Pipelined successor to the single-overlay pixel controller. Composites NUM_LAYERS prioritised overlay layers over a background pixel.
- Overlay layers include font, highlight and cursor layers. The background comes from the image/shape submodule.
- Supports per-layer blend modes, frame-synchronous configuration and frame-counted blinking.
- Sits between the image/text generators and the VGA DAC. Delays the sync and blank signals so they stay aligned with the pixel.

---
 rtl/pixel_compositor_pkg.sv | 15 +
 rtl/pixel_compositor_pipe_blend.sv | 45 ++++
 rtl/pixel_compositor_pipe.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/pixel_compositor_pkg.sv
// rtl/pixel_compositor_pkg.sv - shared constants and helpers for the pixel compositor
package pixel_compositor_pkg;

    localparam logic [1:0] MODE_OPAQUE = 2'b00;
    localparam logic [1:0] MODE_BLEND  = 2'b01;
    localparam logic [1:0] MODE_INVERT = 2'b10;
    localparam logic [1:0] MODE_OFF    = 2'b11;

    localparam int PIPE_LAT = 3;

    function automatic int pix_width(input int r_w, input int g_w, input int b_w);
        return r_w + g_w + b_w;
    endfunction

endpackage

// File: rtl/pixel_compositor_pipe_blend.sv
// rtl/pixel_compositor_pipe_blend.sv - combinational per-pixel blend of winner layer over background
module pixel_blend_unit
    import pixel_compositor_pkg::*;
#(
    parameter int R_WIDTH = 8,
    parameter int G_WIDTH = 8,
    parameter int B_WIDTH = 8
) (
    input  logic [1:0]                         mode_i,
    input  logic                               hit_i,
    input  logic [R_WIDTH+G_WIDTH+B_WIDTH-1:0] layer_i,
    input  logic [R_WIDTH+G_WIDTH+B_WIDTH-1:0] bg_i,
    output logic [R_WIDTH+G_WIDTH+B_WIDTH-1:0] pix_o
);

    // Channel c covers {B G R} with red in the least significant bits.
    for (genvar c = 0; c < 3; c++) begin : g_ch
        localparam int CW = (c == 0) ? R_WIDTH : (c == 1) ? G_WIDTH : B_WIDTH;
        localparam int CO = (c == 0) ? 0 : (c == 1) ? R_WIDTH : R_WIDTH + G_WIDTH;

        logic [CW-1:0] lay_ch;
        logic [CW-1:0] bg_ch;
        logic [CW:0]   sum_ch;
        logic [CW-1:0] out_ch;

        assign lay_ch = layer_i[CO +: CW];
        assign bg_ch  = bg_i[CO +: CW];
        assign sum_ch = {1'b0, lay_ch} + {1'b0, bg_ch};

        always_comb begin
            out_ch = bg_ch;
            if (hit_i) begin
                case (mode_i)
                    MODE_OPAQUE: out_ch = lay_ch;
                    MODE_BLEND:  out_ch = sum_ch[CW:1];
                    MODE_INVERT: out_ch = ~bg_ch;
                    default:     out_ch = bg_ch;
                endcase
            end
        end

        assign pix_o[CO +: CW] = out_ch;
    end

endmodule

// File: rtl/pixel_compositor_pipe.sv
// rtl/pixel_compositor_pipe.sv - 3-stage prioritised overlay compositor with frame-synchronous config
module pixel_compositor_pipe
    import pixel_compositor_pkg::*;
#(
    parameter int NUM_LAYERS      = 4,
    parameter int R_WIDTH         = 8,
    parameter int G_WIDTH         = 8,
    parameter int B_WIDTH         = 8,
    parameter int BLINK_LOG2      = 5,
    parameter int FRAME_CNT_WIDTH = 8
) (
    input  logic                                          CLOCK,
    input  logic                                          RESET,
    input  logic                                          FrameStart,
    input  logic                                          ActiveIn,
    input  logic                                          HSyncIn,
    input  logic                                          VSyncIn,
    input  logic [R_WIDTH+G_WIDTH+B_WIDTH-1:0]            BgPix,
    input  logic [NUM_LAYERS-1:0]                         LayerHit,
    input  logic [NUM_LAYERS*(R_WIDTH+G_WIDTH+B_WIDTH)-1:0] LayerPix,
    input  logic [2*NUM_LAYERS-1:0]                       CfgMode,
    input  logic [NUM_LAYERS-1:0]                         CfgBlinkMask,
    output logic [R_WIDTH+G_WIDTH+B_WIDTH-1:0]            PixBus,
    output logic                                          ActiveOut,
    output logic                                          HSyncOut,
    output logic                                          VSyncOut,
    output logic [FRAME_CNT_WIDTH-1:0]                    FrameCount
);

    localparam int PW = pix_width(R_WIDTH, G_WIDTH, B_WIDTH);

    logic [2*NUM_LAYERS-1:0]    shadow_mode_q;
    logic [NUM_LAYERS-1:0]      shadow_mask_q;
    logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q;
    logic [FRAME_CNT_WIDTH-1:0] frame_cnt_d;
    logic [2*NUM_LAYERS-1:0]    eff_mode;
    logic [NUM_LAYERS-1:0]      eff_mask;

    // The pixel arriving with FrameStart already sees the new config and frame number.
    assign eff_mode    = FrameStart ? CfgMode      : shadow_mode_q;
    assign eff_mask    = FrameStart ? CfgBlinkMask : shadow_mask_q;
    assign frame_cnt_d = FrameStart ? frame_cnt_q + FRAME_CNT_WIDTH'(1) : frame_cnt_q;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            shadow_mode_q <= '1;
            shadow_mask_q <= '0;
            frame_cnt_q   <= '0;
        end else begin
            shadow_mode_q <= eff_mode;
            shadow_mask_q <= eff_mask;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign FrameCount = frame_cnt_q;

    logic [PW-1:0]              s1_bg_q;
    logic [NUM_LAYERS-1:0]      s1_hit_q;
    logic [NUM_LAYERS*PW-1:0]   s1_pix_q;
    logic [2*NUM_LAYERS-1:0]    s1_mode_q;
    logic [NUM_LAYERS-1:0]      s1_mask_q;
    logic                       s1_blink_q;
    logic                       s1_act_q;
    logic                       s1_hs_q;
    logic                       s1_vs_q;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            s1_bg_q    <= '0;
            s1_hit_q   <= '0;
            s1_pix_q   <= '0;
            s1_mode_q  <= '1;
            s1_mask_q  <= '0;
            s1_blink_q <= 1'b0;
            s1_act_q   <= 1'b0;
            s1_hs_q    <= 1'b0;
            s1_vs_q    <= 1'b0;
        end else begin
            s1_bg_q    <= BgPix;
            s1_hit_q   <= LayerHit;
            s1_pix_q   <= LayerPix;
            s1_mode_q  <= eff_mode;
            s1_mask_q  <= eff_mask;
            s1_blink_q <= frame_cnt_d[BLINK_LOG2-1];
            s1_act_q   <= ActiveIn;
            s1_hs_q    <= HSyncIn;
            s1_vs_q    <= VSyncIn;
        end
    end

    logic          win_found;
    logic [PW-1:0] win_pix;
    logic [1:0]    win_mode;

    // Scan from the lowest priority up so the lowest eligible index wins.
    always_comb begin
        win_found = 1'b0;
        win_pix   = '0;
        win_mode  = MODE_OFF;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (s1_hit_q[i] && (s1_mode_q[2*i +: 2] != MODE_OFF) &&
                !(s1_mask_q[i] && s1_blink_q)) begin
                win_found = 1'b1;
                win_pix   = s1_pix_q[i*PW +: PW];
                win_mode  = s1_mode_q[2*i +: 2];
            end
        end
    end

    logic [PW-1:0] s2_pix_q;
    logic [1:0]    s2_mode_q;
    logic [PW-1:0] s2_bg_q;
    logic          s2_hit_q;
    logic          s2_act_q;
    logic          s2_hs_q;
    logic          s2_vs_q;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            s2_pix_q  <= '0;
            s2_mode_q <= MODE_OFF;
            s2_bg_q   <= '0;
            s2_hit_q  <= 1'b0;
            s2_act_q  <= 1'b0;
            s2_hs_q   <= 1'b0;
            s2_vs_q   <= 1'b0;
        end else begin
            s2_pix_q  <= win_pix;
            s2_mode_q <= win_mode;
            s2_bg_q   <= s1_bg_q;
            s2_hit_q  <= win_found;
            s2_act_q  <= s1_act_q;
            s2_hs_q   <= s1_hs_q;
            s2_vs_q   <= s1_vs_q;
        end
    end

    logic [PW-1:0] blend_pix;

    pixel_blend_unit #(
        .R_WIDTH (R_WIDTH),
        .G_WIDTH (G_WIDTH),
        .B_WIDTH (B_WIDTH)
    ) u_blend (
        .mode_i  (s2_mode_q),
        .hit_i   (s2_hit_q),
        .layer_i (s2_pix_q),
        .bg_i    (s2_bg_q),
        .pix_o   (blend_pix)
    );

    logic [PW-1:0] s3_pix_q;
    logic          s3_act_q;
    logic          s3_hs_q;
    logic          s3_vs_q;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            s3_pix_q <= '0;
            s3_act_q <= 1'b0;
            s3_hs_q  <= 1'b0;
            s3_vs_q  <= 1'b0;
        end else begin
            s3_pix_q <= s2_act_q ? blend_pix : '0;
            s3_act_q <= s2_act_q;
            s3_hs_q  <= s2_hs_q;
            s3_vs_q  <= s2_vs_q;
        end
    end

    assign PixBus    = s3_pix_q;
    assign ActiveOut = s3_act_q;
    assign HSyncOut  = s3_hs_q;
    assign VSyncOut  = s3_vs_q;

endmodule
